alu_issue: RTL and testbench

Issue/writeback stage wrapped around the combinational 8-bit `alu`. It accepts instructions over a valid/ready handshake and reads operands from a small register file plus the carry flag. It drives registered operands into the ALU and writes `q`/`cout` back. Shift/rotate ops (4'hC–4'hF) can be repeated up to 8 times by iterating the ALU over several cycles.

---
 rtl/alu_issue.sv | 172 +++++++++++++++++
 tb/tb_alu_issue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/writeback stage around an external combinational 8-bit ALU: operand
// read with forwarding, multi-cycle iteration of shift/rotate ops, and writeback.
module alu_issue #(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_xy,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic              in_imm_en,
    input  logic [7:0]        in_imm,
    input  logic [2:0]        in_cnt,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_xy,
    output logic              alu_cin,
    input  logic [7:0]        alu_q,
    input  logic              alu_cout,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [7:0]        wb_data,
    output logic              wb_carry,
    output logic              carry_flag,
    output logic              zero_flag,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0][7:0] regs_q, regs_d;
    logic                 c_q, c_d;
    logic                 z_q, z_d;
    logic                 e_valid_q, e_valid_d;
    logic [2:0]           e_rem_q, e_rem_d;
    logic [REG_AW-1:0]    e_rd_q, e_rd_d;
    logic [7:0]           alu_a_q, alu_a_d;
    logic [7:0]           alu_b_q, alu_b_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic                 alu_xy_q, alu_xy_d;
    logic                 alu_cin_q, alu_cin_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0]    wb_rd_q, wb_rd_d;
    logic [7:0]           wb_data_q, wb_data_d;
    logic                 wb_carry_q, wb_carry_d;

    logic                 fwd_s;
    logic                 accept_s;

    // The last execute cycle both completes and frees the slot for a new instruction.
    assign fwd_s    = e_valid_q && (e_rem_q == 3'd0);
    assign in_ready = !e_valid_q || (e_rem_q == 3'd0);
    assign accept_s = in_valid && in_ready;

    // Next-state: iteration/completion of the current instruction, then accept.
    always_comb begin
        regs_d     = regs_q;
        c_d        = c_q;
        z_d        = z_q;
        e_valid_d  = e_valid_q;
        e_rem_d    = e_rem_q;
        e_rd_d     = e_rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_xy_d   = alu_xy_q;
        alu_cin_d  = alu_cin_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_carry_d = wb_carry_q;

        if (e_valid_q) begin
            if (e_rem_q != 3'd0) begin
                alu_a_d   = alu_q;
                alu_cin_d = alu_cout;
                e_rem_d   = e_rem_q - 3'd1;
            end else begin
                regs_d[e_rd_q] = alu_q;
                c_d            = alu_cout;
                z_d            = (alu_q == 8'h00);
                wb_valid_d     = 1'b1;
                wb_rd_d        = e_rd_q;
                wb_data_d      = alu_q;
                wb_carry_d     = alu_cout;
                e_valid_d      = 1'b0;
            end
        end else begin
            e_valid_d = 1'b0;
        end

        // Operands come from the completing result when it targets the same register.
        if (accept_s) begin
            if (fwd_s && (e_rd_q == in_rd)) begin
                alu_a_d = alu_q;
            end else begin
                alu_a_d = regs_q[in_rd];
            end
            if (in_imm_en) begin
                alu_b_d = in_imm;
            end else if (fwd_s && (e_rd_q == in_rs)) begin
                alu_b_d = alu_q;
            end else begin
                alu_b_d = regs_q[in_rs];
            end
            alu_cin_d = fwd_s ? alu_cout : c_q;
            alu_op_d  = in_op;
            alu_xy_d  = in_xy;
            e_rd_d    = in_rd;
            e_valid_d = 1'b1;
            e_rem_d   = (in_op[3:2] == 2'b11) ? in_cnt : 3'd0;
        end else begin
            e_rd_d = e_rd_d;
        end
    end

    // State registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            e_valid_q  <= 1'b0;
            e_rem_q    <= 3'd0;
            e_rd_q     <= '0;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_op_q   <= 4'h0;
            alu_xy_q   <= 1'b0;
            alu_cin_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= 8'h00;
            wb_carry_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            c_q        <= c_d;
            z_q        <= z_d;
            e_valid_q  <= e_valid_d;
            e_rem_q    <= e_rem_d;
            e_rd_q     <= e_rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_xy_q   <= alu_xy_d;
            alu_cin_q  <= alu_cin_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_carry_q <= wb_carry_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_xy     = alu_xy_q;
    assign alu_cin    = alu_cin_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_carry   = wb_carry_q;
    assign carry_flag = c_q;
    assign zero_flag  = z_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU closes the loop, directed
// instructions push expected writebacks, a negedge monitor pops and compares.
module tb_alu_issue;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic       in_xy;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic       in_imm_en;
    logic [7:0] in_imm;
    logic [2:0] in_cnt;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic       alu_xy, alu_cin;
    logic [7:0] alu_q;
    logic       alu_cout;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       wb_carry;
    logic       carry_flag, zero_flag;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    typedef struct packed {
        logic [1:0] rd;
        logic [7:0] data;
        logic       c;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    alu_issue #(.REG_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_xy(in_xy), .in_rd(in_rd), .in_rs(in_rs),
        .in_imm_en(in_imm_en), .in_imm(in_imm), .in_cnt(in_cnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_xy(alu_xy), .alu_cin(alu_cin),
        .alu_q(alu_q), .alu_cout(alu_cout),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0 pass b, 8 add, 9 add with carry, C shift, D rotate through carry.
    always_comb begin
        logic [8:0] sum;
        sum      = 9'd0;
        alu_q    = 8'h00;
        alu_cout = 1'b0;
        case (alu_op)
            4'h0: alu_q = alu_b;
            4'h8: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_q = sum[7:0]; alu_cout = sum[8]; end
            4'h9: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin}; alu_q = sum[7:0]; alu_cout = sum[8]; end
            4'hC: if (alu_xy) begin alu_q = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0]; end
                  else        begin alu_q = {alu_a[6:0], 1'b0}; alu_cout = alu_a[7]; end
            4'hD: if (alu_xy) begin alu_q = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
                  else        begin alu_q = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
            4'hE: if (alu_xy) begin alu_q = {alu_a[7], alu_a[7:1]}; alu_cout = alu_a[0]; end
                  else        begin alu_q = {alu_a[6:0], 1'b0}; alu_cout = alu_a[7]; end
            default: begin alu_q = alu_a ^ alu_b; alu_cout = 1'b0; end
        endcase
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: every writeback must match the oldest expected record.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_unexpected: rd=%0d data=0x%02h carry=%0b, none expected", wb_rd, wb_data, wb_carry);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_rd", {6'd0, wb_rd}, {6'd0, e.rd});
                check("wb_data", wb_data, e.data);
                check("wb_carry", {7'd0, wb_carry}, {7'd0, e.c});
            end
        end
    end

    task automatic set_instr(input logic [3:0] op, input logic xy, input logic [1:0] rd,
                             input logic [1:0] rs, input logic imm_en, input logic [7:0] imm,
                             input logic [2:0] cnt);
        in_op = op; in_xy = xy; in_rd = rd; in_rs = rs;
        in_imm_en = imm_en; in_imm = imm; in_cnt = cnt;
    endtask

    // Offer an instruction and return #1 after the edge that accepts it.
    task automatic issue(input logic [3:0] op, input logic xy, input logic [1:0] rd,
                         input logic [1:0] rs, input logic imm_en, input logic [7:0] imm,
                         input logic [2:0] cnt);
        int waited;
        set_instr(op, xy, rd, rs, imm_en, imm, cnt);
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 30) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic peek(input string name, input logic [1:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check(name, dbg_data, exp);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain", {7'd0, sb.size() == 0}, 8'h01);
    endtask

    initial begin
        int lows;
        rst_n = 1'b1; in_valid = 1'b0; dbg_addr = 2'd0;
        set_instr(4'h0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 3'd0);

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) peek("rst_reg", a[1:0], 8'h00);
        check("rst_carry", {7'd0, carry_flag}, 8'h00);
        check("rst_zero", {7'd0, zero_flag}, 8'h00);
        check("rst_ready", {7'd0, in_ready}, 8'h01);
        check("rst_wb_valid", {7'd0, wb_valid}, 8'h00);
        #16 rst_n = 1'b1;
        @(posedge clk); #1;

        // Forwarding chain on consecutive cycles
        sb.push_back('{rd: 2'd0, data: 8'hFF, c: 1'b0});
        issue(4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 8'hFF, 3'd0);
        sb.push_back('{rd: 2'd0, data: 8'h00, c: 1'b1});
        issue(4'h8, 1'b0, 2'd0, 2'd0, 1'b1, 8'h01, 3'd0);
        sb.push_back('{rd: 2'd1, data: 8'h01, c: 1'b0});
        issue(4'h9, 1'b0, 2'd1, 2'd1, 1'b1, 8'h00, 3'd0);
        check("chain_zero", {7'd0, zero_flag}, 8'h01);
        check("chain_carry", {7'd0, carry_flag}, 8'h01);
        @(posedge clk); #1;
        peek("chain_r1", 2'd1, 8'h01);
        check("chain_carry2", {7'd0, carry_flag}, 8'h00);

        // Load-immediate with one-edge writeback latency
        sb.push_back('{rd: 2'd1, data: 8'h5A, c: 1'b0});
        issue(4'h0, 1'b0, 2'd1, 2'd0, 1'b1, 8'h5A, 3'd0);
        check("ldi_wb_early", {7'd0, wb_valid}, 8'h00);
        @(posedge clk); #1;
        check("ldi_wb_valid", {7'd0, wb_valid}, 8'h01);
        peek("ldi_r1", 2'd1, 8'h5A);

        // Multi-shift: 0x81 << 3 = 0x08, in_ready low for exactly 2 cycles
        sb.push_back('{rd: 2'd2, data: 8'h81, c: 1'b0});
        issue(4'h0, 1'b0, 2'd2, 2'd0, 1'b1, 8'h81, 3'd0);
        sb.push_back('{rd: 2'd2, data: 8'h08, c: 1'b0});
        issue(4'hC, 1'b0, 2'd2, 2'd0, 1'b0, 8'h00, 3'd2);
        lows = 0;
        while (in_ready !== 1'b1 && lows < 20) begin
            lows++;
            @(posedge clk); #1;
        end
        check("shift_ready_low", lows[7:0], 8'd2);
        drain();
        peek("shift_r2", 2'd2, 8'h08);

        // Rotate right through carry: 0x01,c=1 -> 0x80,c=1 -> 0xC0,c=0
        sb.push_back('{rd: 2'd3, data: 8'h01, c: 1'b0});
        issue(4'h0, 1'b0, 2'd3, 2'd0, 1'b1, 8'h01, 3'd0);
        sb.push_back('{rd: 2'd2, data: 8'h00, c: 1'b1});
        issue(4'h8, 1'b0, 2'd2, 2'd0, 1'b1, 8'hF8, 3'd0);
        sb.push_back('{rd: 2'd3, data: 8'hC0, c: 1'b0});
        issue(4'hD, 1'b1, 2'd3, 2'd0, 1'b0, 8'h00, 3'd1);
        drain();
        check("rot_carry", {7'd0, carry_flag}, 8'h00);
        peek("rot_r3", 2'd3, 8'hC0);

        // Reset mid-shift with a second instruction held under backpressure
        sb.push_back('{rd: 2'd2, data: 8'h81, c: 1'b0});
        issue(4'h0, 1'b0, 2'd2, 2'd0, 1'b1, 8'h81, 3'd0);
        issue(4'hE, 1'b1, 2'd2, 2'd0, 1'b0, 8'h00, 3'd7);
        set_instr(4'h0, 1'b0, 2'd0, 2'd0, 1'b1, 8'h33, 3'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_low", {7'd0, in_ready}, 8'h00);
            @(posedge clk); #1;
        end
        check("bp_ready_low", {7'd0, in_ready}, 8'h00);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_wb_valid", {7'd0, wb_valid}, 8'h00);
        peek("midrst_r2", 2'd2, 8'h00);
        peek("midrst_r0", 2'd0, 8'h00);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        peek("post_rst_r2", 2'd2, 8'h00);
        check("post_rst_carry", {7'd0, carry_flag}, 8'h00);
        check("sb_empty", sb.size()[7:0], 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
